// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcodes, default widths and the A-to-D opcode mapping helper
// used by the multiple-outstanding master.
package tl_ul_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int DATA_W_DEF  = 64;
  localparam int SIZE_W_DEF  = 8;
  localparam int SRC_W_DEF   = 3;
  localparam int NUM_SRC_DEF = 8;

  localparam logic [2:0] PUT_FULL_DATA_A    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA_A = 3'd1;
  localparam logic [2:0] GET_A              = 3'd4;
  localparam logic [2:0] ACCESS_ACK_D       = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA_D  = 3'd1;

  // A Get is answered with AccessAckData; both Put flavours with a plain AccessAck.
  function automatic logic [2:0] exp_d_opcode(input logic [2:0] a_opcode);
    return (a_opcode == GET_A) ? ACCESS_ACK_DATA_D : ACCESS_ACK_D;
  endfunction

endpackage

// File: rtl/tl_src_alloc.sv
// Source-ID pool: busy bitmap, lowest-free priority encoder and outstanding counter.
// An ID cleared this cycle only becomes allocatable next cycle (encoder reads busy_q).
module tl_src_alloc
  import tl_ul_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int SRC_W   = SRC_W_DEF,
  parameter int CNT_W   = $clog2(NUM_SRC + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic               clr_en,
  input  logic [SRC_W-1:0]   clr_id,
  output logic               free_any,
  output logic [SRC_W-1:0]   alloc_id,
  output logic [NUM_SRC-1:0] busy,
  output logic [CNT_W-1:0]   outstanding
);

  logic [NUM_SRC-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    free_any = 1'b0;
    alloc_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_any = 1'b1;
        alloc_id = SRC_W'(i);
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (clr_en && clr_id == SRC_W'(i)) busy_d[i] = 1'b0;
      if (set_en && alloc_id == SRC_W'(i)) busy_d[i] = 1'b1;
    end
    outstanding_d = outstanding_q + CNT_W'(set_en) - CNT_W'(clr_en);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      outstanding_q <= '0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign busy        = busy_q;
  assign outstanding = outstanding_q;

endmodule

// File: rtl/tl_ul_master_mo.sv
// TileLink-UL master with up to NUM_SRC outstanding transactions: one-entry A
// output register, source-ID matching of D beats, one-entry completion register.
module tl_ul_master_mo
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SIZE_W  = SIZE_W_DEF,
  parameter int SRC_W   = SRC_W_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  localparam int STRB_W = DATA_W / 8,
  localparam int CNT_W  = $clog2(NUM_SRC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_opcode,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [SIZE_W-1:0] req_size,
  input  logic [STRB_W-1:0] req_mask,
  input  logic [DATA_W-1:0] req_data,
  output logic [SRC_W-1:0]  req_src,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [2:0]        a_opcode,
  output logic [2:0]        a_param,
  output logic [ADDR_W-1:0] a_address,
  output logic [SIZE_W-1:0] a_size,
  output logic [STRB_W-1:0] a_mask,
  output logic [DATA_W-1:0] a_data,
  output logic [SRC_W-1:0]  a_source,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [2:0]        d_opcode,
  input  logic [2:0]        d_param,
  input  logic [SIZE_W-1:0] d_size,
  input  logic [SRC_W-1:0]  d_sink,
  input  logic [SRC_W-1:0]  d_source,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_error,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [SRC_W-1:0]  rsp_src,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic              proto_err,
  output logic [CNT_W-1:0]  outstanding
);

  logic               free_any, req_fire, d_fire, d_known, d_exp_get, d_bad;
  logic [SRC_W-1:0]   alloc_id;
  logic [NUM_SRC-1:0] busy;

  logic              a_valid_q, a_valid_d;
  logic [2:0]        a_opcode_q, a_opcode_d;
  logic [ADDR_W-1:0] a_address_q, a_address_d;
  logic [SIZE_W-1:0] a_size_q, a_size_d;
  logic [STRB_W-1:0] a_mask_q, a_mask_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [SRC_W-1:0]  a_source_q, a_source_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [SRC_W-1:0]  rsp_src_q, rsp_src_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              proto_err_q, proto_err_d;
  logic [NUM_SRC-1:0] exp_get_q, exp_get_d;

  logic unused_d_fields;
  assign unused_d_fields = ^{d_param, d_size, d_sink};

  assign req_ready = free_any & (!a_valid_q | a_ready);
  assign req_fire  = req_valid & req_ready;
  assign d_ready   = !rsp_valid_q | rsp_ready;
  assign d_fire    = d_valid & d_ready;

  tl_src_alloc #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .CNT_W(CNT_W)) u_alloc (
    .clk        (clk),
    .rst        (rst),
    .set_en     (req_fire),
    .clr_en     (d_fire & d_known),
    .clr_id     (d_source),
    .free_any   (free_any),
    .alloc_id   (alloc_id),
    .busy       (busy),
    .outstanding(outstanding)
  );

  // Sources at or beyond NUM_SRC never match, so they fall out as unknown.
  always_comb begin
    d_known   = 1'b0;
    d_exp_get = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (d_source == SRC_W'(i)) begin
        d_known   = busy[i];
        d_exp_get = exp_get_q[i];
      end
    end
    d_bad = !d_known ||
            (d_opcode != (d_exp_get ? ACCESS_ACK_DATA_D : ACCESS_ACK_D));
  end

  always_comb begin
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_address_d = a_address_q;
    a_size_d    = a_size_q;
    a_mask_d    = a_mask_q;
    a_data_d    = a_data_q;
    a_source_d  = a_source_q;
    exp_get_d   = exp_get_q;
    if (req_fire) begin
      a_valid_d   = 1'b1;
      a_opcode_d  = req_opcode;
      a_address_d = req_address;
      a_size_d    = req_size;
      a_mask_d    = req_mask;
      a_data_d    = req_data;
      a_source_d  = alloc_id;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (alloc_id == SRC_W'(i))
          exp_get_d[i] = (exp_d_opcode(req_opcode) == ACCESS_ACK_DATA_D);
      end
    end else if (a_ready) begin
      a_valid_d = 1'b0;
    end

    rsp_valid_d = rsp_valid_q;
    rsp_src_d   = rsp_src_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    proto_err_d = 1'b0;
    if (d_fire) begin
      rsp_valid_d = 1'b1;
      rsp_src_d   = d_source;
      rsp_data_d  = (d_known && d_exp_get) ? d_data : '0;
      rsp_error_d = d_error | d_bad;
      proto_err_d = d_bad;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: the small per-ID exp_get flags are reset with everything else; a stale flag is harmless only because busy is cleared too.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_address_q <= '0;
      a_size_q    <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      a_source_q  <= '0;
      exp_get_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_address_q <= a_address_d;
      a_size_q    <= a_size_d;
      a_mask_q    <= a_mask_d;
      a_data_q    <= a_data_d;
      a_source_q  <= a_source_d;
      exp_get_q   <= exp_get_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_src_q   <= rsp_src_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign req_src   = alloc_id;
  assign a_valid   = a_valid_q;
  assign a_opcode  = a_opcode_q;
  assign a_param   = 3'd0;
  assign a_address = a_address_q;
  assign a_size    = a_size_q;
  assign a_mask    = a_mask_q;
  assign a_data    = a_data_q;
  assign a_source  = a_source_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_src   = rsp_src_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_tl_ul_master_mo.sv
// Self-checking bench for tl_ul_master_mo: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level reference model.
module tb_tl_ul_master_mo;

  localparam int NUM_SRC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_opcode;
  logic [63:0] req_address;
  logic [7:0]  req_size, req_mask;
  logic [63:0] req_data;
  logic [2:0]  req_src;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param;
  logic [63:0] a_address;
  logic [7:0]  a_size, a_mask;
  logic [63:0] a_data;
  logic [2:0]  a_source;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param;
  logic [7:0]  d_size;
  logic [2:0]  d_sink, d_source;
  logic [63:0] d_data;
  logic        d_error;
  logic        rsp_valid, rsp_ready;
  logic [2:0]  rsp_src;
  logic [63:0] rsp_data;
  logic        rsp_error, proto_err;
  logic [3:0]  outstanding;

  always #5 clk = ~clk;

  tl_ul_master_mo dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_address(req_address), .req_size(req_size), .req_mask(req_mask),
    .req_data(req_data), .req_src(req_src),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_address(a_address), .a_size(a_size), .a_mask(a_mask), .a_data(a_data),
    .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_sink(d_sink), .d_source(d_source), .d_data(d_data),
    .d_error(d_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .proto_err(proto_err),
    .outstanding(outstanding)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: what a TL-UL master must present, kept as plain records.
  typedef struct packed {
    logic v; logic [2:0] op; logic [63:0] addr; logic [7:0] size;
    logic [7:0] mask; logic [63:0] data; logic [2:0] src;
  } a_rec_t;
  typedef struct packed {
    logic v; logic [2:0] src; logic [63:0] data; logic err;
  } rsp_rec_t;

  bit       m_busy [NUM_SRC];
  bit       m_get  [NUM_SRC];
  a_rec_t   m_a;
  rsp_rec_t m_r;
  bit       m_perr;
  bit       last_req_fire;
  int       last_req_src;

  function automatic int lowest_free();
    for (int i = 0; i < NUM_SRC; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int n_busy();
    int n = 0;
    for (int i = 0; i < NUM_SRC; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_SRC; i++) begin m_busy[i] = 0; m_get[i] = 0; end
    m_a = '0; m_r = '0; m_perr = 0;
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle();
    int lf;
    bit exp_rr, exp_dr, rf, df, known, bad;
    #1;
    lf     = lowest_free();
    exp_rr = (lf >= 0) && (!m_a.v || a_ready);
    exp_dr = !m_r.v || rsp_ready;
    check("req_ready", req_ready, exp_rr);
    check("d_ready", d_ready, exp_dr);
    check("a_valid", a_valid, m_a.v);
    check("a_opcode", a_opcode, m_a.op);
    check("a_param", a_param, 0);
    check("a_address", a_address, m_a.addr);
    check("a_size", a_size, m_a.size);
    check("a_mask", a_mask, m_a.mask);
    check("a_data", a_data, m_a.data);
    check("a_source", a_source, m_a.src);
    check("rsp_valid", rsp_valid, m_r.v);
    check("rsp_src", rsp_src, m_r.src);
    check("rsp_data", rsp_data, m_r.data);
    check("rsp_error", rsp_error, m_r.err);
    check("proto_err", proto_err, m_perr);
    check("outstanding", outstanding, 64'(n_busy()));
    rf = req_valid && exp_rr;
    df = d_valid && exp_dr;
    if (rf) check("req_src", req_src, 64'(lf));
    last_req_fire = rf;
    last_req_src  = lf;
    if (rst) begin
      model_reset();
      last_req_fire = 0;
    end else begin
      if (rf) m_a = '{1'b1, req_opcode, req_address, req_size, req_mask, req_data, 3'(lf)};
      else if (m_a.v && a_ready) m_a.v = 0;
      m_perr = 0;
      if (df) begin
        known = (int'(d_source) < NUM_SRC) && m_busy[d_source];
        bad   = !known || (d_opcode != (m_get[d_source] ? 3'd1 : 3'd0));
        m_r   = '{1'b1, d_source, (known && m_get[d_source]) ? d_data : 64'd0, d_error || bad};
        m_perr = bad;
        if (known) m_busy[d_source] = 0;
      end else if (m_r.v && rsp_ready) begin
        m_r.v = 0;
      end
      if (rf) begin
        m_busy[lf] = 1;
        m_get[lf]  = (req_opcode == 3'd4);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_req(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data);
    bit fired = 0;
    req_valid = 1; req_opcode = op; req_address = addr;
    req_size = 8'd3; req_mask = 8'hFF; req_data = data;
    for (int i = 0; i < 50 && !fired; i++) begin
      cycle();
      fired = last_req_fire;
    end
    if (!fired) check("req_fire_timeout", 0, 1);
    req_valid = 0;
  endtask

  task automatic send_d(input logic [2:0] src, input logic [2:0] op, input logic [63:0] data);
    d_valid = 1; d_source = src; d_opcode = op; d_data = data; d_error = 0;
    cycle();
    d_valid = 0;
  endtask

  task automatic drain();
    int guard = 0;
    rsp_ready = 1; a_ready = 1; req_valid = 0;
    while (n_busy() > 0 && guard < 64) begin
      for (int i = NUM_SRC - 1; i >= 0; i--)
        if (m_busy[i]) d_source = 3'(i);
      send_d(d_source, m_get[d_source] ? 3'd1 : 3'd0, 64'hA5A5_0000_0000_0000 | 64'(guard));
      guard++;
    end
    if (n_busy() > 0) check("drain_timeout", 0, 1);
    cycle();
  endtask

  initial begin
    rst = 1; req_valid = 0; req_opcode = 0; req_address = 0; req_size = 0;
    req_mask = 0; req_data = 0; a_ready = 1; d_valid = 0; d_opcode = 0;
    d_param = 0; d_size = 0; d_sink = 0; d_source = 0; d_data = 0; d_error = 0;
    rsp_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_a_valid", a_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_outstanding", outstanding, 0);

    // PutFull, then AccessAck several cycles later.
    do_req(3'd0, 64'h1000_0000, 64'hDEAD_BEEF_CAFE_BABE);
    check("t1_a_valid", a_valid, 1);
    check("t1_a_source", a_source, 0);
    check("t1_a_opcode", a_opcode, 0);
    check("t1_a_data", a_data, 64'hDEAD_BEEF_CAFE_BABE);
    repeat (4) cycle();
    check("t1_outstanding_busy", outstanding, 1);
    send_d(3'd0, 3'd0, 64'h1234);
    check("t1_rsp_src", rsp_src, 0);
    check("t1_rsp_data", rsp_data, 0);
    check("t1_rsp_error", rsp_error, 0);
    check("t1_outstanding_idle", outstanding, 0);

    // Get answered in the cycle right after its A beat.
    do_req(3'd4, 64'h1000_0000, 64'h0);
    cycle();
    send_d(3'd0, 3'd1, 64'hBEEF_DEAD_BEEF_DEAD);
    check("t2_rsp_data", rsp_data, 64'hBEEF_DEAD_BEEF_DEAD);
    check("t2_rsp_error", rsp_error, 0);

    // Eight back-to-back Puts fill the pool; freeing 5 makes 5 the next ID.
    req_valid = 1; req_opcode = 3'd0; req_size = 8'd3; req_mask = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      req_address = 64'h2000_0000 + 64'(8 * k);
      req_data    = 64'(k);
      cycle();
      check("t3_src_order", 64'(last_req_src), 64'(k));
    end
    cycle();
    check("t3_outstanding_full", outstanding, 8);
    check("t3_req_ready_full", req_ready, 0);
    d_valid = 1; d_source = 3'd5; d_opcode = 3'd0; d_error = 0;
    cycle();
    d_valid = 0;
    cycle();
    check("t3_reissue_fire", last_req_fire, 1);
    check("t3_reissue_src", 64'(last_req_src), 5);
    req_valid = 0;
    drain();

    // Three Gets answered out of order.
    req_valid = 1; req_opcode = 3'd4;
    for (int k = 0; k < 3; k++) begin
      req_address = 64'h3000_0000 + 64'(8 * k);
      cycle();
    end
    req_valid = 0;
    cycle();
    send_d(3'd2, 3'd1, 64'h2222_2222_2222_2222);
    check("t4_first_src", rsp_src, 2);
    check("t4_first_data", rsp_data, 64'h2222_2222_2222_2222);
    send_d(3'd0, 3'd1, 64'h0000_0000_0000_0F0F);
    check("t4_second_src", rsp_src, 0);
    check("t4_second_data", rsp_data, 64'h0000_0000_0000_0F0F);
    send_d(3'd1, 3'd1, 64'h1111_1111_1111_1111);
    check("t4_third_src", rsp_src, 1);
    check("t4_third_data", rsp_data, 64'h1111_1111_1111_1111);
    check("t4_all_free", outstanding, 0);

    // Protocol errors: unknown source, then wrong opcode for a Get.
    send_d(3'd6, 3'd0, 64'h77);
    check("t5_unknown_perr", proto_err, 1);
    check("t5_unknown_err", rsp_error, 1);
    check("t5_unknown_outstanding", outstanding, 0);
    cycle();
    check("t5_perr_pulse", proto_err, 0);
    do_req(3'd4, 64'h4000_0000, 64'h0);
    cycle();
    send_d(3'd0, 3'd0, 64'h0);
    check("t5_wrongop_perr", proto_err, 1);
    check("t5_wrongop_err", rsp_error, 1);
    check("t5_wrongop_freed", outstanding, 0);

    // A-channel backpressure, D backpressure, then reset mid-flight.
    a_ready = 0;
    do_req(3'd0, 64'h5000_0000, 64'h0101_0101_0101_0101);
    req_valid = 1; req_data = 64'h0202_0202_0202_0202;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t6_a_data_stable", a_data, 64'h0101_0101_0101_0101);
      check("t6_req_ready_stall", req_ready, 0);
    end
    a_ready = 1;
    cycle();
    req_valid = 0;
    rsp_ready = 0;
    send_d(3'd0, 3'd0, 64'h0);
    d_valid = 1; d_source = 3'd1; d_opcode = 3'd0;
    #1;
    check("t6_d_ready_blocked", d_ready, 0);
    cycle();
    d_valid = 0;
    rst = 1;
    cycle();
    rst = 0;
    check("t6_rst_a_valid", a_valid, 0);
    check("t6_rst_rsp_valid", rsp_valid, 0);
    check("t6_rst_perr", proto_err, 0);
    check("t6_rst_outstanding", outstanding, 0);
    check("t6_rst_a_data", a_data, 0);
    rsp_ready = 1;
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int busy_ids[$];
      int pick;
      req_valid   = ($urandom_range(0, 1) == 1);
      pick        = $urandom_range(0, 2);
      req_opcode  = (pick == 0) ? 3'd0 : (pick == 1) ? 3'd1 : 3'd4;
      req_address = {$urandom, $urandom};
      req_size    = 8'($urandom_range(0, 3));
      req_mask    = 8'($urandom);
      req_data    = {$urandom, $urandom};
      a_ready     = ($urandom_range(0, 3) != 0);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      d_valid     = ($urandom_range(0, 2) == 0);
      busy_ids.delete();
      for (int i = 0; i < NUM_SRC; i++) if (m_busy[i]) busy_ids.push_back(i);
      if (busy_ids.size() > 0 && $urandom_range(0, 9) < 8)
        d_source = 3'(busy_ids[$urandom_range(0, busy_ids.size() - 1)]);
      else
        d_source = 3'($urandom_range(0, 7));
      d_opcode = m_get[d_source] ? 3'd1 : 3'd0;
      if ($urandom_range(0, 9) == 0) d_opcode = d_opcode ^ 3'd1;
      d_error  = ($urandom_range(0, 7) == 0);
      d_data   = {$urandom, $urandom};
      d_param  = 3'($urandom);
      d_size   = 8'($urandom);
      d_sink   = 3'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 0; d_valid = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_ul_master_mo.md
Name: tl_ul_master_mo

Overview:
- Parametrised TileLink-UL master with multiple outstanding transactions; next generation of the single-outstanding master.
- Accepts Get/PutFullData/PutPartialData requests from a local client and allocates a free source ID from a pool of NUM_SRC.
- Drives channel A through a one-entry output register, matches channel D responses to outstanding entries by source ID, and returns completions to the client.
- Sits between a core/DMA client and the TL-UL crossbar.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; STRB_W = DATA_W/8.
- SIZE_W, 8, size field width.
- SRC_W, 3, source/sink field width.
- NUM_SRC, 8, outstanding-transaction limit; must be ≤ 2^SRC_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  request accepted this cycle.
- req_opcode  in  3  0 = PutFull, 1 = PutPartial, 4 = Get.
- req_address  in  ADDR_W  byte address.
- req_size  in  SIZE_W  log2 bytes.
- req_mask  in  STRB_W  byte mask.
- req_data  in  DATA_W  write data.
- req_src  out  SRC_W  source ID allocated to the accepted request (valid when req_valid & req_ready).
- a_valid / a_ready  out / in  1  channel A handshake.
- a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source  out  3, 3, ADDR_W, SIZE_W, STRB_W, DATA_W, SRC_W  channel A fields.
- d_valid / d_ready  in / out  1  channel D handshake.
- d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error  in  3, 3, SIZE_W, SRC_W, SRC_W, DATA_W, 1  channel D fields.
- rsp_valid / rsp_ready  out / in  1  completion handshake.
- rsp_src  out  SRC_W  completed source ID.
- rsp_data  out  DATA_W  read data; 0 for Put.
- rsp_error  out  1  d_error OR protocol error.
- proto_err  out  1  one-cycle pulse: D with an unknown source or a wrong opcode.
- outstanding  out  $clog2(NUM_SRC+1)  count of busy IDs.

Behaviour:
- Reset: a_valid = 0, rsp_valid = 0, proto_err = 0, busy bitmap = 0, outstanding = 0, all A/rsp data registers = 0. A reset mid-transaction drops all entries; late D beats after reset are treated as unknown-source.
- Allocation: free = ~busy (registered). Lowest-index free ID is chosen.
- req_ready = (|free) & (!a_valid | a_ready).
- On req fire: A register loads the fields with a_param = 0 and a_source = the allocated ID; busy[id] is set; expected_data[id] = (opcode == Get). Latency from req fire to a_valid is one cycle.
- A channel: a_valid and the A fields hold stable until a_ready. Back-to-back requests every cycle are supported while a_ready = 1 and IDs remain free.
- d_ready = !rsp_valid | rsp_ready (one-entry output register).
- On D fire:
  - Known source with the correct opcode (AccessAckData = 1 for Get, AccessAck = 0 for Put): load rsp; clear busy[d_source]; proto_err = 0.
  - Unknown source (busy = 0, or d_source ≥ NUM_SRC): proto_err = 1; rsp is loaded with rsp_error = 1; busy is unchanged.
  - Wrong opcode for a busy source: proto_err = 1; rsp_error = 1; entry is freed.
- rsp_data = d_data for Get, 0 for Put. rsp_error = d_error | protocol error.
- Same cycle alloc and free: permitted on different IDs. An ID freed in a cycle is not reallocated until the next cycle. outstanding = outstanding + alloc - free, and never wraps.
- Full (outstanding == NUM_SRC): req_ready = 0; D traffic continues.
- Responses may arrive in any order; rsp order follows D order.
- Zero-latency D (D fire in the cycle after the A fire of the same ID) is legal.

Decomposition:
- Package tl_ul_pkg holds:
  - opcode constants GET_A = 4, PUT_FULL_DATA_A = 0, PUT_PARTIAL_DATA_A = 1, ACCESS_ACK_D = 0, ACCESS_ACK_DATA_D = 1;
  - default widths;
  - the helper function exp_d_opcode(a_opcode).
- Sub-module tl_src_alloc: busy bitmap, lowest-free priority encoder, set/clear ports, outstanding counter.

Test Plan:
- PutFull addr 0x1000_0000, data 0xDEAD_BEEF_CAFE_BABE, mask 0xFF, size 3 → a_source = 0, a_opcode = 0 one cycle after fire. D AccessAck with source 0 after 5 cycles → rsp_src = 0, rsp_data = 0, rsp_error = 0, outstanding 1 → 0.
- Get addr 0x1000_0000 issued, then D AccessAckData with source 0 and data 0xBEEF_DEAD_BEEF_DEAD in the next cycle → rsp_data = 0xBEEF_DEAD_BEEF_DEAD.
- 8 back-to-back PutFull to 0x2000_0000 + 8k with a_ready = 1 → sources 0..7 in order, outstanding = 8, req_ready = 0. Ack source 5 → source 5 is reissued to the next request one cycle after the ack.
- 3 Gets out; D responses in order sources 2, 0, 1 with distinct data → rsp stream follows the same order with correct data; busy bitmap clears fully.
- D with source 6 while idle → proto_err pulse, rsp_error = 1, outstanding stays 0. AccessAck to an outstanding Get → proto_err, and the entry is freed.
- a_ready held 0 for 4 cycles → A fields stable and req_ready = 0. rsp_ready = 0 with a response pending → d_ready = 0. Assert rst mid-flight → all outputs return to their reset values in the next cycle.
